// File: rtl/reqack_rx_fifo.sv
// Four-phase req/ack receiver that buffers each accepted word in a DEPTH-entry FIFO
// and presents the head of the FIFO on a valid/ready streaming port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ack=0, waiting for req with en=1 and space in the FIFO
//   WAIT_LOW | ack=1, word already stored, waiting for req to drop
module reqack_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     req,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ack,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // Full check uses the pre-edge count, so a pop never frees a slot in the same cycle.
    assign full = (count == CW'(DEPTH));
    assign push = (state == IDLE) && req && en && !full;
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (push) state_nxt = WAIT_LOW;
            WAIT_LOW: if (!req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack     = (state == WAIT_LOW);
        m_valid = (count != '0);
        m_data  = m_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_reqack_rx_fifo.sv
// Bench for reqack_rx_fifo: directed scenario tasks plus a randomized run
// checked against a queue-based model of the handshake and FIFO rules.
module tb_reqack_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             req;
    logic [WIDTH-1:0] data_in;
    logic             ack;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ack;
    logic [WIDTH-1:0] sunk[$];
    int               max_count;

    reqack_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .data_in (data_in),
        .ack     (ack),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: log sink transfers, take the edge, apply the rules to the model, settle at negedge.
    task automatic cyc();
        bit do_pop;
        bit do_push;
        if (m_valid && m_ready) sunk.push_back(m_data);
        if (int'(count) > max_count) max_count = int'(count);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ack = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && m_ready;
            do_push = !m_ack && req && en && (mq.size() < DEPTH);
            if (m_ack && !req) m_ack = 1'b0;
            if (do_push) m_ack = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(data_in);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, output bit ok);
        int n;
        ok = 1'b1;
        data_in = d;
        req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ack && n < 40);
        if (!ack) ok = 1'b0;
        req = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (ack && n < 40);
        if (ack) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req = 1'b1; m_ready = 1'b1; data_in = 8'h33;
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++; if (ack !== 1'b0)     begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", m_valid); end
        n_cmp++; if (count !== 3'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", m_data); end
        req = 1'b0; m_ready = 1'b0; en = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        en = 1'b1; data_in = 8'hA5; req = 1'b1; m_ready = 1'b0;
        cyc();
        n_cmp++; if (ack !== 1'b1)   begin n_err++; $display("FAIL single_ack_up got %b want 1", ack); end
        req = 1'b0;
        cyc();
        n_cmp++; if (ack !== 1'b0)     begin n_err++; $display("FAIL single_ack_down got %b want 0", ack); end
        n_cmp++; if (count !== 3'd1)   begin n_err++; $display("FAIL single_count got %0d want 1", count); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", m_valid); end
        n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", m_data); end
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        n_cmp++; if (count !== 3'd0)   begin n_err++; $display("FAIL single_pop_count got %0d want 0", count); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %b want 0", m_valid); end
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            data_in = WIDTH'(i); req = 1'b1;
            cyc();
            n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL fill_ack word %0d got %b want 1", i, ack); end
            req = 1'b0;
            cyc();
        end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
        data_in = 8'h05; req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL full_stall cycle %0d got ack %b want 0", i, ack); end
        end
        n_cmp++; if (m_data !== 8'h01) begin n_err++; $display("FAIL full_head got %h want 01", m_data); end
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        n_cmp++; if (ack !== 1'b0)   begin n_err++; $display("FAIL full_pop_no_bypass got ack %b want 0", ack); end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_pop_count got %0d want 3", count); end
        cyc();
        n_cmp++; if (ack !== 1'b1)   begin n_err++; $display("FAIL full_late_ack got %b want 1", ack); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_refill_count got %0d want 4", count); end
        req = 1'b0;
        cyc();
        m_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            n_cmp++; if (m_data !== WIDTH'(k)) begin n_err++; $display("FAIL fill_drain got %h want %h", m_data, WIDTH'(k)); end
            cyc();
        end
        m_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_empty got %0d want 0", count); end
    endtask

    task automatic test_drain_wrap();
        bit ok;
        sunk.delete(); max_count = 0; m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_word(8'h10 + WIDTH'(i), ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_handshake word %0d timed out", i); end
        end
        repeat (3) cyc();
        m_ready = 1'b0;
        n_cmp++; if (sunk.size() != 10) begin n_err++; $display("FAIL wrap_words got %0d want 10", sunk.size()); end
        for (int i = 0; i < 10 && i < sunk.size(); i++) begin
            n_cmp++;
            if (sunk[i] !== 8'h10 + WIDTH'(i)) begin
                n_err++; $display("FAIL wrap_order idx %0d got %h want %h", i, sunk[i], 8'h10 + WIDTH'(i));
            end
        end
        n_cmp++; if (max_count > 2) begin n_err++; $display("FAIL wrap_max_count got %0d want <=2", max_count); end
    endtask

    task automatic test_en_gating();
        m_ready = 1'b0; en = 1'b0; data_in = 8'h77; req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++; if (ack !== 1'b0 || count !== 3'd0) begin
                n_err++; $display("FAIL en_stall cycle %0d got ack %b count %0d want 0 0", i, ack, count);
            end
        end
        en = 1'b1;
        cyc();
        n_cmp++; if (ack !== 1'b1 || count !== 3'd1) begin
            n_err++; $display("FAIL en_rise got ack %b count %0d want 1 1", ack, count);
        end
        en = 1'b0;
        cyc();
        n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL en_waitlow_hold got %b want 1", ack); end
        req = 1'b0;
        cyc();
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL en_waitlow_drop got %b want 0", ack); end
        data_in = 8'h78; req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++; if (ack !== 1'b0 || count !== 3'd1) begin
                n_err++; $display("FAIL en_restall cycle %0d got ack %b count %0d want 0 1", i, ack, count);
            end
        end
        en = 1'b1;
        cyc();
        n_cmp++; if (ack !== 1'b1 || count !== 3'd2) begin
            n_err++; $display("FAIL en_resume got ack %b count %0d want 1 2", ack, count);
        end
        req = 1'b0;
        cyc();
        m_ready = 1'b1;
        n_cmp++; if (m_data !== 8'h77) begin n_err++; $display("FAIL en_data0 got %h want 77", m_data); end
        cyc();
        n_cmp++; if (m_data !== 8'h78) begin n_err++; $display("FAIL en_data1 got %h want 78", m_data); end
        cyc();
        m_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL en_empty got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        m_ready = 1'b0; en = 1'b1;
        send_word(8'hA1, ok);
        send_word(8'hA2, ok);
        data_in = 8'hA3; req = 1'b1;
        cyc();
        n_cmp++; if (ack !== 1'b1 || count !== 3'd3) begin
            n_err++; $display("FAIL rstmid_pre got ack %b count %0d want 1 3", ack, count);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (ack !== 1'b0 || count !== 3'd0 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_clear got ack %b count %0d valid %b want 0 0 0", ack, count, m_valid);
        end
        cyc();
        n_cmp++; if (ack !== 1'b1 || count !== 3'd1 || m_data !== 8'hA3) begin
            n_err++; $display("FAIL rstmid_reaccept got ack %b count %0d data %h want 1 1 a3", ack, count, m_data);
        end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_data;
        for (int i = 0; i < 600; i++) begin
            exp_data = (mq.size() != 0) ? mq[0] : '0;
            n_cmp++;
            if (ack !== m_ack || int'(count) != mq.size() || m_valid !== (mq.size() != 0) || m_data !== exp_data) begin
                n_err++;
                $display("FAIL random cycle %0d got ack %b count %0d valid %b data %h want %b %0d %b %h",
                         i, ack, count, m_valid, m_data, m_ack, mq.size(), mq.size() != 0, exp_data);
            end
            if (!req && !ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    req = 1'b1; data_in = WIDTH'($urandom);
                end
            end else if (req && ack) begin
                if ($urandom_range(0, 1) == 0) req = 1'b0;
            end
            en      = ($urandom_range(0, 4) != 0);
            m_ready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            if (i % 150 > 100) m_ready = 1'b1;
            cyc();
        end
        req = 1'b0; m_ready = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 1'b0; m_ready = 1'b0; data_in = '0;
        m_ack = 1'b0; max_count = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_drain_wrap();
        test_en_gating();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
